// File: rtl/elevator_call_scheduler.sv
// Four-floor elevator call scheduler: latches call buttons and serves them with a SCAN policy,
// stepping one floor per MOVE_TICKS ticks and holding the door for DOOR_TICKS ticks per stop.
module elevator_call_scheduler #(
  parameter int MOVE_TICKS = 2,
  parameter int DOOR_TICKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] call_req,
  output logic [1:0] floor,
  output logic [1:0] state,
  output logic       dir_up,
  output logic       moving,
  output logic       door_open,
  output logic [3:0] pending,
  output logic       arrive
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_MOVING = 2'b01,
    ST_DOOR   = 2'b10
  } state_t;

  localparam int MW = (MOVE_TICKS > 1) ? $clog2(MOVE_TICKS) : 1;
  localparam int DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
  localparam logic [MW-1:0] MOVE_LOAD = MW'(MOVE_TICKS - 1);
  localparam logic [DW-1:0] DOOR_LOAD = DW'(DOOR_TICKS - 1);

  state_t          state_q, state_d;
  logic [1:0]      floor_q, floor_d;
  logic            dir_up_q, dir_up_d;
  logic [MW-1:0]   move_cnt_q, move_cnt_d;
  logic [DW-1:0]   door_cnt_q, door_cnt_d;
  logic [3:0]      pending_q, pending_d;
  logic            arrive_q, arrive_d;
  logic [3:0]      clear_mask;
  logic [3:0]      hold_mask;
  logic [3:0]      floor_oh;
  logic [1:0]      floor_step;
  logic            at_end;

  function automatic logic [3:0] above_of(input logic [3:0] p, input logic [1:0] f);
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) > f) m[i] = p[i];
    end
    return m;
  endfunction

  function automatic logic [3:0] below_of(input logic [3:0] p, input logic [1:0] f);
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) < f) m[i] = p[i];
    end
    return m;
  endfunction

  assign floor_oh   = 4'b0001 << floor_q;
  assign hold_mask  = (state_q == ST_DOOR) ? floor_oh : 4'b0000;
  assign floor_step = dir_up_q ? (floor_q + 2'd1) : (floor_q - 2'd1);
  assign at_end     = dir_up_q ? (floor_q == 2'd3) : (floor_q == 2'd0);

  // A stop's clear overrides a simultaneous call; the open-door floor's button only holds the door.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pend
      assign pending_d[gi] = !clear_mask[gi] &&
                             (pending_q[gi] || (call_req[gi] && !hold_mask[gi]));
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    dir_up_d   = dir_up_q;
    move_cnt_d = move_cnt_q;
    door_cnt_d = door_cnt_q;
    clear_mask = 4'b0000;
    arrive_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          if (pending_q[floor_q]) begin
            state_d    = ST_DOOR;
            clear_mask = floor_oh;
            door_cnt_d = DOOR_LOAD;
          end else if ((dir_up_q && |above_of(pending_q, floor_q)) ||
                       (!dir_up_q && !(|below_of(pending_q, floor_q)) &&
                        |above_of(pending_q, floor_q))) begin
            dir_up_d   = 1'b1;
            state_d    = ST_MOVING;
            move_cnt_d = MOVE_LOAD;
          end else if (|below_of(pending_q, floor_q)) begin
            dir_up_d   = 1'b0;
            state_d    = ST_MOVING;
            move_cnt_d = MOVE_LOAD;
          end
        end
      end
      ST_MOVING: begin
        if (tick) begin
          if (move_cnt_q != '0) begin
            move_cnt_d = move_cnt_q - MW'(1);
          end else if (at_end) begin
            state_d = ST_IDLE;
          end else begin
            floor_d  = floor_step;
            arrive_d = 1'b1;
            if (pending_q[floor_step]) begin
              state_d    = ST_DOOR;
              clear_mask = 4'b0001 << floor_step;
              door_cnt_d = DOOR_LOAD;
            end else if (dir_up_q ? |above_of(pending_q, floor_step)
                                  : |below_of(pending_q, floor_step)) begin
              move_cnt_d = MOVE_LOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_DOOR: begin
        if (call_req[floor_q]) begin
          door_cnt_d = DOOR_LOAD;
        end else if (tick) begin
          if (door_cnt_q != '0) begin
            door_cnt_d = door_cnt_q - DW'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      floor_q    <= 2'd0;
      dir_up_q   <= 1'b1;
      move_cnt_q <= '0;
      door_cnt_q <= '0;
      pending_q  <= 4'b0000;
      arrive_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      floor_q    <= floor_d;
      dir_up_q   <= dir_up_d;
      move_cnt_q <= move_cnt_d;
      door_cnt_q <= door_cnt_d;
      pending_q  <= pending_d;
      arrive_q   <= arrive_d;
    end
  end

  assign floor     = floor_q;
  assign state     = state_q;
  assign dir_up    = dir_up_q;
  assign moving    = (state_q == ST_MOVING);
  assign door_open = (state_q == ST_DOOR);
  assign pending   = pending_q;
  assign arrive    = arrive_q;

endmodule
